// File: rtl/led_pwm_fader.sv
// Multi-channel LED PWM brightness engine. Duty changes only at the PWM period
// boundary, either as an instant jump or as a one-LSB ramp step every STEP_DIV periods.

module led_pwm_fader_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] wr_target,
  input  logic       wr_instant,
  input  logic       boundary,
  input  logic       step,
  input  logic [7:0] slot_cnt,
  output logic [7:0] duty,
  output logic       pwm,
  output logic       done
);
  logic [7:0] target;
  logic       pend_inst;
  logic [7:0] duty_nxt;

  always_comb begin
    duty_nxt = duty;
    if (pend_inst)                    duty_nxt = target;
    else if (step && duty < target)   duty_nxt = duty + 8'd1;
    else if (step && duty > target)   duty_nxt = duty - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target    <= '0;
      pend_inst <= 1'b0;
      duty      <= '0;
      pwm       <= 1'b0;
      done      <= 1'b0;
    end else begin
      pwm  <= (slot_cnt < duty);
      done <= boundary && (duty_nxt != duty) && (duty_nxt == target);
      if (boundary) begin
        duty      <= duty_nxt;
        pend_inst <= 1'b0;
      end
      // a command landing on the boundary cycle wins over the clear above,
      // so it is applied at the following boundary
      if (wr) begin
        target    <= wr_target;
        pend_inst <= wr_instant;
      end
    end
  end
endmodule

module led_pwm_fader #(
  parameter int CHANNELS = 2,
  parameter int PRESCALE = 195,
  parameter int STEP_DIV = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CW-1:0]         cmd_chan,
  input  logic [7:0]            cmd_target,
  input  logic                  cmd_instant,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic [8*CHANNELS-1:0] level,
  output logic [CHANNELS-1:0]   ramp_done
);
  localparam int PW = $clog2(PRESCALE);
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [PW-1:0]               pre_cnt;
  logic [7:0]                  slot_cnt;
  logic [SW-1:0]               step_cnt;
  logic                        tick, boundary, step, accept;
  logic [CHANNELS-1:0]         lane_wr;
  logic [CHANNELS-1:0][7:0]    duty;

  assign cmd_ready = ~reset;
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (pre_cnt == PW'(PRESCALE - 1));
  assign boundary  = tick && (slot_cnt == 8'd255);
  assign step      = boundary && (step_cnt == SW'(STEP_DIV - 1));
  assign level     = duty;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pre_cnt  <= '0;
      slot_cnt <= '0;
      step_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (tick) slot_cnt <= slot_cnt + 8'd1;
      if (boundary) step_cnt <= (step_cnt == SW'(STEP_DIV - 1)) ? '0 : step_cnt + SW'(1);
    end
  end

  // out-of-range channel numbers match no lane and are dropped
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign lane_wr[i] = accept && (32'(cmd_chan) == i);
    led_pwm_fader_lane u_lane (
      .clk        (CLOCK_50),
      .reset      (reset),
      .wr         (lane_wr[i]),
      .wr_target  (cmd_target),
      .wr_instant (cmd_instant),
      .boundary   (boundary),
      .step       (step),
      .slot_cnt   (slot_cnt),
      .duty       (duty[i]),
      .pwm        (pwm_out[i]),
      .done       (ramp_done[i])
    );
  end
endmodule

// File: tb/tb_led_pwm_fader.sv
// Scoreboard bench for led_pwm_fader: a period-arithmetic reference model queues
// the expected outputs every cycle and a negedge monitor compares them.

module tb_led_pwm_fader;
  localparam int CH = 3, P = 2, SD = 2, PER = 256 * P;

  logic            clk = 1'b0, reset = 1'b1;
  logic            cmd_valid = 1'b0, cmd_instant = 1'b0, cmd_ready;
  logic [1:0]      cmd_chan = '0;
  logic [7:0]      cmd_target = '0;
  logic [CH-1:0]   pwm_out, ramp_done;
  logic [8*CH-1:0] level;

  always #5 clk = ~clk;

  led_pwm_fader #(.CHANNELS(CH), .PRESCALE(P), .STEP_DIV(SD)) dut (
    .CLOCK_50(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_target(cmd_target), .cmd_instant(cmd_instant),
    .pwm_out(pwm_out), .level(level), .ramp_done(ramp_done));

  typedef struct packed {
    logic [CH-1:0]   pwm;
    logic [8*CH-1:0] lvl;
    logic [CH-1:0]   done;
  } obs_t;

  obs_t   exp_q[$];
  int     total = 0, bad = 0;
  int     m_duty[CH], m_tgt[CH];
  bit     m_pend[CH];
  longint n = 0;
  int     hi_cnt[CH], dn_cnt[CH];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: position inside the period and ramp cadence come straight from
  // the number of clock edges since reset.
  always @(posedge clk) begin : model
    obs_t e;
    int   slot, nd;
    bit   bnd, stp;
    e = '0;
    if (reset) begin
      for (int i = 0; i < CH; i++) begin m_duty[i] = 0; m_tgt[i] = 0; m_pend[i] = 0; end
      n = 0;
    end else begin
      slot = int'((n / P) % 256);
      bnd  = (n % PER) == PER - 1;
      stp  = bnd && ((n / PER) % SD) == SD - 1;
      for (int i = 0; i < CH; i++) begin
        e.pwm[i] = slot < m_duty[i];
        if (bnd) begin
          if (m_pend[i])   nd = m_tgt[i];
          else if (stp)    nd = m_duty[i] + ((m_tgt[i] > m_duty[i]) ? 1 : 0) - ((m_tgt[i] < m_duty[i]) ? 1 : 0);
          else             nd = m_duty[i];
          e.done[i] = (nd != m_duty[i]) && (nd == m_tgt[i]);
          m_duty[i] = nd;
          m_pend[i] = 0;
        end
      end
      if (cmd_valid && cmd_chan < CH) begin
        m_tgt[cmd_chan]  = cmd_target;
        m_pend[cmd_chan] = cmd_instant;
      end
      n++;
    end
    for (int i = 0; i < CH; i++) e.lvl[8*i +: 8] = m_duty[i][7:0];
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pwm_out",   64'(pwm_out),   64'(e.pwm));
      chk("level",     64'(level),     64'(e.lvl));
      chk("ramp_done", 64'(ramp_done), 64'(e.done));
      chk("cmd_ready", 64'(cmd_ready), 64'(!reset));
      for (int i = 0; i < CH; i++) begin
        if (pwm_out[i] === 1'b1)   hi_cnt[i]++;
        if (ramp_done[i] === 1'b1) dn_cnt[i]++;
      end
    end
  end

  task automatic cyc(int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic cmd(int ch, int t, bit inst);
    cmd_valid = 1'b1; cmd_chan = 2'(ch); cmd_target = 8'(t); cmd_instant = inst;
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_level(int ch, int v, int budget);
    int k = 0;
    while (level[8*ch +: 8] !== 8'(v) && k < budget) begin cyc(1); k++; end
    chk($sformatf("wait_level ch%0d", ch), 64'(level[8*ch +: 8]), 64'(v));
  endtask

  task automatic pwm_window(int ch, int want);
    int c0;
    cyc(2);
    c0 = hi_cnt[ch];
    cyc(PER);
    chk($sformatf("pwm_high_per_period ch%0d", ch), 64'(hi_cnt[ch] - c0), 64'(want));
  endtask

  initial begin
    int d0, k;
    for (int i = 0; i < CH; i++) begin hi_cnt[i] = 0; dn_cnt[i] = 0; end
    // reset held with a command pending: nothing may be accepted
    cmd_valid = 1'b1; cmd_chan = 2'd0; cmd_target = 8'h55; cmd_instant = 1'b1;
    cyc(5);
    cmd_valid = 1'b0; reset = 1'b0;
    cyc(PER + 10);
    chk("idle_level", 64'(level), 64'd0);

    // instant jump
    cmd(0, 128, 1'b1);
    wait_level(0, 128, PER + 4);
    pwm_window(0, 128 * P);
    pwm_window(1, 0);
    chk("instant_done_once", 64'(dn_cnt[0]), 64'd1);

    // ramp 0 -> 4
    cmd(1, 4, 1'b0);
    for (int v = 1; v <= 4; v++) wait_level(1, v, SD * PER + PER + 4);
    cyc(PER);
    chk("ramp_done_once", 64'(dn_cnt[1]), 64'd1);

    // extremes and ignored channel
    cmd(2, 255, 1'b1);
    wait_level(2, 255, PER + 4);
    pwm_window(2, 255 * P);
    cmd(2, 0, 1'b1);
    wait_level(2, 0, PER + 4);
    pwm_window(2, 0);
    cmd(3, 77, 1'b1);
    cyc(2 * PER);
    chk("bad_chan_ignored", 64'(level), 64'({8'd0, 8'd4, 8'd128}));

    // mid-ramp retarget reverses direction
    cmd(0, 0, 1'b1);
    wait_level(0, 0, PER + 4);
    cmd(0, 10, 1'b0);
    wait_level(0, 6, 7 * SD * PER + PER);
    cmd(0, 2, 1'b0);
    d0 = dn_cnt[0];
    for (int v = 5; v >= 2; v--) wait_level(0, v, SD * PER + PER + 4);
    cyc(SD * PER);
    chk("retarget_done_once", 64'(dn_cnt[0] - d0), 64'd1);

    // command accepted on the boundary cycle waits a full period
    k = 0;
    while ((n % PER) != PER - 1 && k < 2 * PER) begin cyc(1); k++; end
    cmd(2, 200, 1'b1);
    chk("collision_not_yet", 64'(level[23:16]), 64'd0);
    cyc(PER - 10);
    chk("collision_still_old", 64'(level[23:16]), 64'd0);
    wait_level(2, 200, 20);

    // reset in the middle of a ramp
    cmd(1, 0, 1'b1);
    wait_level(1, 0, PER + 4);
    cmd(1, 9, 1'b0);
    wait_level(1, 3, 4 * SD * PER + PER);
    reset = 1'b1;
    cyc(1);
    chk("reset_level", 64'(level), 64'd0);
    chk("reset_pwm", 64'(pwm_out), 64'd0);
    reset = 1'b0;
    d0 = dn_cnt[1];
    cyc(3 * PER);
    chk("no_resume_level", 64'(level), 64'd0);
    chk("no_resume_done", 64'(dn_cnt[1] - d0), 64'd0);

    // random traffic, including back-to-back bursts
    for (int r = 0; r < 40; r++) begin
      cmd($urandom_range(0, 3), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      if (r % 8 != 7) cyc($urandom_range(0, PER));
    end
    cyc(4 * PER);

    chk("queue_drained", 64'(exp_q.size() <= 1), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
